// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: emits configurable multi-beat packets of LFSR or
// incrementing data, with inter-packet gaps, round-robin destinations and graceful stop.
module axis_pkt_gen #(
    parameter int          TDATAW    = 32,
    parameter int          TDESTW    = 4,
    parameter int          TIDW      = 2,
    parameter int          NUM_DEST  = 4,
    parameter int          PKT_LEN_W = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          SRC_ID    = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 STOP,
    input  logic [15:0]          CFG_NUM_PKTS,
    input  logic [PKT_LEN_W-1:0] CFG_PKT_LEN,
    input  logic [PKT_LEN_W-1:0] CFG_GAP,
    input  logic                 CFG_MODE,
    input  logic                 CFG_RR,
    input  logic [TDESTW-1:0]    CFG_DEST,
    output logic                 AXIS_M_TVALID,
    input  logic                 AXIS_M_TREADY,
    output logic [TDATAW-1:0]    AXIS_M_TDATA,
    output logic                 AXIS_M_TLAST,
    output logic [TIDW-1:0]      AXIS_M_TID,
    output logic [TDESTW-1:0]    AXIS_M_TDEST,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [15:0]          PKT_COUNT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int                   REP     = TDATAW / 16;
    localparam logic [TDESTW-1:0]    RR_LAST = TDESTW'(NUM_DEST - 1);
    localparam logic [TDESTW-1:0]    DEST_1  = TDESTW'(1);
    localparam logic [PKT_LEN_W-1:0] LEN_1   = PKT_LEN_W'(1);

    // Architectural state
    logic [1:0]           r_state;
    logic [15:0]          r_num_pkts;
    logic [PKT_LEN_W-1:0] r_len_m1;
    logic [PKT_LEN_W-1:0] r_gap;
    logic                 r_mode;
    logic                 r_rr;
    logic [TDESTW-1:0]    r_dest;
    logic [15:0]          r_lfsr;
    logic [31:0]          r_cnt;
    logic [PKT_LEN_W-1:0] r_beat;
    logic [TDESTW-1:0]    r_rr_ptr;
    logic [15:0]          r_pkt_count;
    logic                 r_stop_pend;
    logic [PKT_LEN_W-1:0] r_gap_cnt;
    logic                 r_tvalid;
    logic [TDATAW-1:0]    r_tdata;
    logic                 r_tlast;
    logic [TDESTW-1:0]    r_tdest;
    logic                 r_done;

    // Next-state values
    logic [1:0]           w_state_next;
    logic [15:0]          w_num_pkts_next;
    logic [PKT_LEN_W-1:0] w_len_m1_next;
    logic [PKT_LEN_W-1:0] w_gap_next;
    logic                 w_mode_next;
    logic                 w_rr_next;
    logic [TDESTW-1:0]    w_dest_next;
    logic [15:0]          w_lfsr_next;
    logic [31:0]          w_cnt_next;
    logic [PKT_LEN_W-1:0] w_beat_next;
    logic [TDESTW-1:0]    w_rr_ptr_next;
    logic [15:0]          w_pkt_count_next;
    logic                 w_stop_pend_next;
    logic [PKT_LEN_W-1:0] w_gap_cnt_next;
    logic                 w_tvalid_next;
    logic                 w_tlast_next;
    logic [TDESTW-1:0]    w_tdest_next;
    logic                 w_done_next;
    logic                 w_load;
    logic [TDATAW-1:0]    w_data_next;

    // Helper terms
    logic                 w_hs;
    logic                 w_stop_eff;
    logic                 w_final;
    logic                 w_is_last;
    logic [15:0]          w_lfsr_step;
    logic [TDESTW-1:0]    w_rr_step;
    logic [PKT_LEN_W-1:0] w_start_len_m1;
    logic [TDATAW-1:0]    w_lfsr_rep;
    logic [TDATAW-1:0]    w_cnt_ext;

    assign w_hs           = r_tvalid & AXIS_M_TREADY;
    assign w_stop_eff     = r_stop_pend | STOP;
    assign w_final        = (r_num_pkts != 16'd0) && ((r_pkt_count + 16'd1) == r_num_pkts);
    assign w_is_last      = (r_beat == r_len_m1);
    assign w_lfsr_step    = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_rr_step      = (r_rr_ptr == RR_LAST) ? '0 : r_rr_ptr + DEST_1;
    assign w_start_len_m1 = (CFG_PKT_LEN == '0) ? '0 : CFG_PKT_LEN - LEN_1;

    // Data for the beat being loaded is formed from the post-advance source values.
    genvar gi;
    generate
        for (gi = 0; gi < REP; gi++) begin : g_rep
            assign w_lfsr_rep[gi*16 +: 16] = w_lfsr_next;
        end
        if (TDATAW > 32) begin : g_cnt_wide
            assign w_cnt_ext = {{(TDATAW-32){1'b0}}, w_cnt_next};
        end else begin : g_cnt_narrow
            assign w_cnt_ext = w_cnt_next[TDATAW-1:0];
        end
    endgenerate

    assign w_data_next = w_mode_next ? w_cnt_ext : w_lfsr_rep;

    always_comb begin
        w_state_next     = r_state;
        w_num_pkts_next  = r_num_pkts;
        w_len_m1_next    = r_len_m1;
        w_gap_next       = r_gap;
        w_mode_next      = r_mode;
        w_rr_next        = r_rr;
        w_dest_next      = r_dest;
        w_lfsr_next      = r_lfsr;
        w_cnt_next       = r_cnt;
        w_beat_next      = r_beat;
        w_rr_ptr_next    = r_rr_ptr;
        w_pkt_count_next = r_pkt_count;
        w_stop_pend_next = r_stop_pend;
        w_gap_cnt_next   = r_gap_cnt;
        w_tvalid_next    = r_tvalid;
        w_tlast_next     = r_tlast;
        w_tdest_next     = r_tdest;
        w_done_next      = 1'b0;
        w_load           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_num_pkts_next  = CFG_NUM_PKTS;
                    w_len_m1_next    = w_start_len_m1;
                    w_gap_next       = CFG_GAP;
                    w_mode_next      = CFG_MODE;
                    w_rr_next        = CFG_RR;
                    w_dest_next      = CFG_DEST;
                    w_lfsr_next      = LFSR_SEED;
                    w_cnt_next       = '0;
                    w_beat_next      = '0;
                    w_rr_ptr_next    = '0;
                    w_pkt_count_next = '0;
                    w_stop_pend_next = 1'b0;
                    w_state_next     = ST_RUN;
                    w_tvalid_next    = 1'b1;
                    w_tlast_next     = (w_start_len_m1 == '0);
                    w_tdest_next     = CFG_RR ? '0 : CFG_DEST;
                    w_load           = 1'b1;
                end
            end

            ST_RUN: begin
                if (STOP) begin
                    w_stop_pend_next = 1'b1;
                end
                if (w_hs) begin
                    if (r_mode) begin
                        w_cnt_next = r_cnt + 32'd1;
                    end else begin
                        w_lfsr_next = w_lfsr_step;
                    end
                    if (w_is_last) begin
                        w_pkt_count_next = r_pkt_count + 16'd1;
                        w_rr_ptr_next    = w_rr_step;
                        w_beat_next      = '0;
                        if (w_final || w_stop_eff) begin
                            w_state_next     = ST_IDLE;
                            w_tvalid_next    = 1'b0;
                            w_tlast_next     = 1'b0;
                            w_done_next      = 1'b1;
                            w_stop_pend_next = 1'b0;
                        end else if (r_gap != '0) begin
                            w_state_next   = ST_GAP;
                            w_gap_cnt_next = r_gap;
                            w_tvalid_next  = 1'b0;
                            w_tlast_next   = 1'b0;
                        end else begin
                            w_tvalid_next = 1'b1;
                            w_tlast_next  = (r_len_m1 == '0);
                            w_tdest_next  = r_rr ? w_rr_step : r_dest;
                            w_load        = 1'b1;
                        end
                    end else begin
                        w_beat_next   = r_beat + LEN_1;
                        w_tlast_next  = ((r_beat + LEN_1) == r_len_m1);
                        w_load        = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                // A stop seen during the gap ends the run before any new beat is shown.
                if (w_stop_eff) begin
                    w_state_next     = ST_IDLE;
                    w_done_next      = 1'b1;
                    w_stop_pend_next = 1'b0;
                end else if (r_gap_cnt <= LEN_1) begin
                    w_state_next  = ST_RUN;
                    w_tvalid_next = 1'b1;
                    w_tlast_next  = (r_len_m1 == '0);
                    w_tdest_next  = r_rr ? r_rr_ptr : r_dest;
                    w_load        = 1'b1;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - LEN_1;
                end
            end

            default: begin
                w_state_next  = ST_IDLE;
                w_tvalid_next = 1'b0;
                w_tlast_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_num_pkts  <= '0;
            r_len_m1    <= '0;
            r_gap       <= '0;
            r_mode      <= 1'b0;
            r_rr        <= 1'b0;
            r_dest      <= '0;
            r_lfsr      <= LFSR_SEED;
            r_cnt       <= '0;
            r_beat      <= '0;
            r_rr_ptr    <= '0;
            r_pkt_count <= '0;
            r_stop_pend <= 1'b0;
            r_gap_cnt   <= '0;
            r_tvalid    <= 1'b0;
            r_tdata     <= '0;
            r_tlast     <= 1'b0;
            r_tdest     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_num_pkts  <= w_num_pkts_next;
            r_len_m1    <= w_len_m1_next;
            r_gap       <= w_gap_next;
            r_mode      <= w_mode_next;
            r_rr        <= w_rr_next;
            r_dest      <= w_dest_next;
            r_lfsr      <= w_lfsr_next;
            r_cnt       <= w_cnt_next;
            r_beat      <= w_beat_next;
            r_rr_ptr    <= w_rr_ptr_next;
            r_pkt_count <= w_pkt_count_next;
            r_stop_pend <= w_stop_pend_next;
            r_gap_cnt   <= w_gap_cnt_next;
            r_tvalid    <= w_tvalid_next;
            r_tlast     <= w_tlast_next;
            r_tdest     <= w_tdest_next;
            r_done      <= w_done_next;
            if (w_load) begin
                r_tdata <= w_data_next;
            end
        end
    end

    assign AXIS_M_TVALID = r_tvalid;
    assign AXIS_M_TDATA  = r_tdata;
    assign AXIS_M_TLAST  = r_tlast;
    assign AXIS_M_TDEST  = r_tdest;
    assign AXIS_M_TID    = TIDW'(SRC_ID);
    assign BUSY          = (r_state != ST_IDLE);
    assign DONE          = r_done;
    assign PKT_COUNT     = r_pkt_count;

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

Parametrised AXI-Stream traffic generator that drives NoC injection ports with multi-beat packets of pseudo-random or incrementing data. Packet count, packet length, inter-packet gap and destination policy are all configurable. Output beats obey full AXI-Stream valid/ready semantics: data is held under backpressure and the pattern advances only on accepted beats. It sits at each NoC endpoint as the stimulus source, paired with a checker at the sink.

## Interface
- TDATAW, 32, data width; must be a multiple of 16
- TDESTW, 4, destination field width
- TIDW, 2, ID field width
- NUM_DEST, 4, number of destinations cycled in round-robin mode (1..2^TDESTW)
- PKT_LEN_W, 8, width of the packet-length and gap config fields
- LFSR_SEED, 16'hACE1, LFSR reload value; must be non-zero
- SRC_ID, 0, constant value driven on TID

Ports:
- CLK  in  1  clock; all logic on the rising edge
- RST  in  1  synchronous active-high reset
- START  in  1  start pulse; sampled only in IDLE
- STOP  in  1  graceful stop request; sampled only in RUN/GAP
- CFG_NUM_PKTS  in  16  packets to send; 0 = continuous
- CFG_PKT_LEN  in  PKT_LEN_W  beats per packet; 0 is treated as 1
- CFG_GAP  in  PKT_LEN_W  idle cycles between packets
- CFG_MODE  in  1  0 = LFSR data, 1 = incrementing data
- CFG_RR  in  1  0 = fixed destination CFG_DEST, 1 = round-robin
- CFG_DEST  in  TDESTW  fixed destination
- AXIS_M_TVALID  out  1  beat valid
- AXIS_M_TREADY  in  1  downstream ready
- AXIS_M_TDATA  out  TDATAW  beat data
- AXIS_M_TLAST  out  1  last beat of packet
- AXIS_M_TID  out  TIDW  always SRC_ID
- AXIS_M_TDEST  out  TDESTW  packet destination
- BUSY  out  1  high whenever state != IDLE
- DONE  out  1  one-cycle completion pulse
- PKT_COUNT  out  16  packets completed since last START

## Operation
- States: IDLE, RUN, GAP.
- **IDLE:**
  - START latches all CFG_* inputs into shadow registers.
  - START reloads the LFSR with LFSR_SEED, clears the incrementing counter, PKT_COUNT, the beat index and the round-robin pointer.
  - Next state is RUN.
- **RUN:**
  - TVALID is high and presents the current beat.
  - A handshake is TVALID & TREADY. On a handshake, the beat index increments and the data source advances.
  - TLAST = 1 when beat index == len-1.
- **Handshake with TLAST:**
  - PKT_COUNT increments (wraps at 2^16).
  - The round-robin pointer advances modulo NUM_DEST.
  - The beat index clears.
- **Exit from a TLAST handshake:**
  - To IDLE if the final packet is done (PKT_COUNT+1 == CFG_NUM_PKTS with CFG_NUM_PKTS != 0) or a stop is pending. DONE pulses and BUSY drops in the same cycle.
  - Otherwise to GAP if CFG_GAP != 0.
  - Otherwise stay in RUN (back-to-back packet).
- **GAP:** TVALID is low for exactly CFG_GAP cycles, then RUN.
- **STOP:** sets a sticky stop-pending flag.
  - In RUN, the current packet completes normally and the block then goes to IDLE.
  - In GAP, the block goes to IDLE next cycle with DONE pulsed. No partial packet is ever emitted.
- **START outside IDLE:** ignored. Config changes outside IDLE have no effect.
- **LFSR:**
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting left with the feedback bit entering at bit 0.
  - LFSR mode: TDATA = the 16-bit state replicated TDATAW/16 times.
  - The LFSR advances only on a handshake in LFSR mode.
- **Incrementing mode:** TDATA = 32-bit beat counter, zero-extended or truncated to TDATAW. The counter increments per handshake and wraps.
- **TDEST:** CFG_DEST if CFG_RR = 0, else the round-robin pointer. TDEST is constant across a packet.

## Timing
- **Reset values:** TVALID = 0, TLAST = 0, TDATA = 0, TDEST = 0, BUSY = 0, DONE = 0, PKT_COUNT = 0, state = IDLE. The LFSR loads LFSR_SEED.
- **Outputs:** TVALID, TDATA, TLAST and TDEST are registered; TID is constant.
- **Start latency:** START high in cycle N gives TVALID = 1 with beat 0 in cycle N+1.
- **Stability:** while TVALID = 1 and TREADY = 0, TDATA, TLAST and TDEST are held stable.
  - TVALID never drops without a handshake, except on RST.
- **Throughput:** with TREADY held at 1 and CFG_GAP = 0, one beat is accepted per cycle continuously across packet boundaries.
- **Gap timing:** the TLAST handshake in cycle M gives TVALID low in M+1..M+GAP, and the next beat 0 appears in M+GAP+1.
- **DONE:** asserted in the cycle after the final TLAST handshake. TVALID is 0 in that same cycle.
- **Simultaneous START and STOP in IDLE:** START wins. STOP is ignored because it is sampled only in RUN/GAP.
- **RST mid-packet:** TVALID is 0 the next cycle. All state is cleared and no DONE is issued.

## Test plan
- **Fixed destination, LFSR:** NUM_PKTS = 2, PKT_LEN = 3, GAP = 0, MODE = 0, RR = 0, DEST = 5, TREADY = 1.
  - Expect 6 consecutive beats with TDATA = {ACE1,ACE1}, then successive LFSR states.
  - TLAST on beats 3 and 6, TDEST = 5 throughout.
  - DONE one cycle after beat 6, PKT_COUNT = 2.
- **Backpressure:** same config, TREADY toggled randomly.
  - The accepted-beat sequence is identical to the previous test.
  - TDATA, TLAST and TDEST are held while TREADY = 0.
- **Gap and round-robin:** NUM_PKTS = 5, PKT_LEN = 1, GAP = 2, RR = 1, NUM_DEST = 4.
  - TDEST sequence 0,1,2,3,0.
  - Exactly 2 low-TVALID cycles between beats.
- **Continuous mode with STOP:** NUM_PKTS = 0, PKT_LEN = 4, MODE = 1; assert STOP during beat 2 of packet 3.
  - Packet 3 completes with TLAST; TDATA runs 0..11.
  - DONE follows, PKT_COUNT = 3.
- **Length 0 and ignored START:** PKT_LEN = 0.
  - Every beat has TLAST = 1.
  - A START pulse issued mid-run has no effect.
- **Reset mid-packet:** RST asserted during beat 1 of 4.
  - TVALID = 0 the next cycle, BUSY = 0, no DONE.
  - After the next START, data restarts from LFSR_SEED.
